// File: rtl/mlo_loop_pkg.sv
// Shared types and helpers for the MLO multi-layer loop sequencer.
// Holds the controller state encoding and the launch-time configuration check.
package mlo_loop_pkg;

   localparam int FW_IDX_BITS = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_IDX,
      ST_RUN,
      ST_NEXT,
      ST_FIN
   } seq_state_e;

   // A multi-layer run must fit a whole frame in the loopback FIFO.
   function automatic bit cfg_error(input int n_layers, input int frame_beats,
                                    input int n_max_layers, input int fifo_depth);
      return (n_layers == 0) || (n_layers > n_max_layers) || (frame_beats == 0) ||
             ((n_layers > 1) && (frame_beats > fifo_depth));
   endfunction

endpackage

// File: rtl/mlo_loop_sequencer_if.sv
// AXI-Stream style channel (tdata/tvalid/tready) used for every sequencer stream port.
interface mlo_loop_sequencer_if #(
   parameter int W = 256
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mlo_loop_fifo.sv
// Loopback FIFO: RAM array with registered read data, one-cycle write-to-read latency.
// Full/empty come from pointers carrying one extra wrap bit.
module mlo_loop_fifo #(
   parameter int DATA_BITS  = 256,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [DATA_BITS-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready
);
   localparam int ADDR_BITS = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] rd_data_reg;
   logic [ADDR_BITS:0]   wr_ptr_reg;
   logic [ADDR_BITS:0]   rd_ptr_reg;
   logic [ADDR_BITS:0]   rd_ptr_next;
   logic                 empty;
   logic                 full;
   logic                 wr_en;
   logic                 rd_en;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[ADDR_BITS] != rd_ptr_reg[ADDR_BITS]) &&
                  (wr_ptr_reg[ADDR_BITS-1:0] == rd_ptr_reg[ADDR_BITS-1:0]);

   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = rd_data_reg;
   assign s_axis_tready = !full || m_axis_tready;

   assign wr_en       = s_axis_tvalid && s_axis_tready;
   assign rd_en       = m_axis_tvalid && m_axis_tready;
   assign rd_ptr_next = rd_ptr_reg + (ADDR_BITS + 1)'(rd_en);

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + (ADDR_BITS + 1)'(1);
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr_reg[ADDR_BITS-1:0]] <= s_axis_tdata;
   end

   // Prefetch the next head word; forward the incoming beat when it lands on that slot.
   always_ff @(posedge aclk) begin
      if (wr_en && (wr_ptr_reg[ADDR_BITS-1:0] == rd_ptr_next[ADDR_BITS-1:0]))
         rd_data_reg <= s_axis_tdata;
      else
         rd_data_reg <= mem[rd_ptr_next[ADDR_BITS-1:0]];
   end

endmodule

// File: rtl/mlo_loop_sequencer.sv
// Multi-layer loop sequencer: passes one frame through the core n_layers times,
// recirculating intermediate layers through the loopback FIFO.
module mlo_loop_sequencer
   import mlo_loop_pkg::*;
#(
   parameter int DATA_BITS    = 256,
   parameter int CNT_BITS     = FW_IDX_BITS,
   parameter int N_MAX_LAYERS = 16,
   parameter int FIFO_DEPTH   = 32
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                start,
   input  logic [CNT_BITS-1:0] n_layers,
   input  logic [CNT_BITS-1:0] frame_beats,
   output logic                busy,
   output logic                done,
   output logic                err,
   mlo_loop_sequencer_if.slave  s_axis_fs,
   mlo_loop_sequencer_if.master m_axis_core_in,
   mlo_loop_sequencer_if.master m_axis_core_in_fw_idx,
   mlo_loop_sequencer_if.slave  s_axis_core_out,
   mlo_loop_sequencer_if.master m_axis_se
);
   seq_state_e          state_reg, state_next;
   logic [CNT_BITS-1:0] n_layers_reg, frame_beats_reg, layer_reg;
   logic [CNT_BITS-1:0] in_cnt_reg, out_cnt_reg, in_cnt_next, out_cnt_next;
   logic                err_reg;

   logic                 run, in_open, out_open, first_layer, last_layer, cfg_bad;
   logic                 src_valid, sink_ready, in_hs, out_hs, frame_complete;
   logic [DATA_BITS-1:0] src_data;

   logic [DATA_BITS-1:0] fifo_s_tdata, fifo_m_tdata;
   logic                 fifo_s_tvalid, fifo_s_tready, fifo_m_tvalid, fifo_m_tready;

   mlo_loop_fifo #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (fifo_s_tdata),
      .s_axis_tvalid (fifo_s_tvalid),
      .s_axis_tready (fifo_s_tready),
      .m_axis_tdata  (fifo_m_tdata),
      .m_axis_tvalid (fifo_m_tvalid),
      .m_axis_tready (fifo_m_tready)
   );

   assign run         = (state_reg == ST_RUN);
   assign in_open     = (in_cnt_reg < frame_beats_reg);
   assign out_open    = (out_cnt_reg < frame_beats_reg);
   assign first_layer = (layer_reg == '0);
   assign last_layer  = (layer_reg == n_layers_reg - CNT_BITS'(1));
   assign cfg_bad     = cfg_error(32'(n_layers_reg), 32'(frame_beats_reg), N_MAX_LAYERS, FIFO_DEPTH);

   assign src_valid  = first_layer ? s_axis_fs.tvalid : fifo_m_tvalid;
   assign src_data   = first_layer ? s_axis_fs.tdata : fifo_m_tdata;
   assign sink_ready = last_layer ? m_axis_se.tready : fifo_s_tready;

   assign in_hs          = run && in_open && src_valid && m_axis_core_in.tready;
   assign out_hs         = run && out_open && s_axis_core_out.tvalid && sink_ready;
   assign in_cnt_next    = in_cnt_reg + CNT_BITS'(in_hs);
   assign out_cnt_next   = out_cnt_reg + CNT_BITS'(out_hs);
   // Leave RUN on the cycle of the final handshake so NEXT follows immediately.
   assign frame_complete = (in_cnt_next == frame_beats_reg) && (out_cnt_next == frame_beats_reg);

   always_ff @(posedge aclk) begin
      if (areset) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start) state_next = ST_CHECK;
         ST_CHECK: state_next = cfg_bad ? ST_FIN : ST_IDX;
         ST_IDX:   if (m_axis_core_in_fw_idx.tready) state_next = ST_RUN;
         ST_RUN:   if (frame_complete) state_next = ST_NEXT;
         ST_NEXT:  state_next = last_layer ? ST_FIN : ST_IDX;
         ST_FIN:   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy                         = (state_reg != ST_IDLE);
      done                         = (state_reg == ST_FIN);
      err                          = err_reg;
      m_axis_core_in_fw_idx.tvalid = (state_reg == ST_IDX);
      m_axis_core_in_fw_idx.tdata  = layer_reg;
      m_axis_core_in.tvalid        = run && in_open && src_valid;
      m_axis_core_in.tdata         = src_data;
      s_axis_fs.tready             = run && first_layer && in_open && m_axis_core_in.tready;
      fifo_m_tready                = run && !first_layer && in_open && m_axis_core_in.tready;
      s_axis_core_out.tready       = run && out_open && sink_ready;
      m_axis_se.tvalid             = run && last_layer && out_open && s_axis_core_out.tvalid;
      m_axis_se.tdata              = s_axis_core_out.tdata;
      fifo_s_tvalid                = run && !last_layer && out_open && s_axis_core_out.tvalid;
      fifo_s_tdata                 = s_axis_core_out.tdata;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         n_layers_reg    <= '0;
         frame_beats_reg <= '0;
         layer_reg       <= '0;
         in_cnt_reg      <= '0;
         out_cnt_reg     <= '0;
         err_reg         <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: if (start) begin
               n_layers_reg    <= n_layers;
               frame_beats_reg <= frame_beats;
               layer_reg       <= '0;
               err_reg         <= 1'b0;
            end
            ST_CHECK: if (cfg_bad) err_reg <= 1'b1;
            ST_IDX: if (m_axis_core_in_fw_idx.tready) begin
               in_cnt_reg  <= '0;
               out_cnt_reg <= '0;
            end
            ST_RUN: begin
               in_cnt_reg  <= in_cnt_next;
               out_cnt_reg <= out_cnt_next;
            end
            ST_NEXT: if (!last_layer) layer_reg <= layer_reg + CNT_BITS'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mlo_loop_sequencer.sv
// Randomized bench for mlo_loop_sequencer: the bench plays fs source, core and se sink,
// and predicts se data as input + n_layers * per-pass increment.
module tb_mlo_loop_sequencer;
   localparam int DATA_BITS  = 256;
   localparam int CNT_BITS   = 16;
   localparam int N_MAX      = 16;
   localparam int DEPTH      = 32;
   localparam int GUARD      = 6000;

   typedef logic [DATA_BITS-1:0] data_t;

   logic                clk = 1'b0;
   logic                areset = 1'b1;
   logic                start = 1'b0;
   logic [CNT_BITS-1:0] n_layers = '0;
   logic [CNT_BITS-1:0] frame_beats = '0;
   logic                busy, done, err;

   mlo_loop_sequencer_if #(.W(DATA_BITS)) fs_if ();
   mlo_loop_sequencer_if #(.W(DATA_BITS)) ci_if ();
   mlo_loop_sequencer_if #(.W(CNT_BITS))  idx_if ();
   mlo_loop_sequencer_if #(.W(DATA_BITS)) co_if ();
   mlo_loop_sequencer_if #(.W(DATA_BITS)) se_if ();

   always #5 clk = ~clk;

   mlo_loop_sequencer #(
      .DATA_BITS    (DATA_BITS),
      .CNT_BITS     (CNT_BITS),
      .N_MAX_LAYERS (N_MAX),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .aclk                  (clk),
      .areset                (areset),
      .start                 (start),
      .n_layers              (n_layers),
      .frame_beats           (frame_beats),
      .busy                  (busy),
      .done                  (done),
      .err                   (err),
      .s_axis_fs             (fs_if),
      .m_axis_core_in        (ci_if),
      .m_axis_core_in_fw_idx (idx_if),
      .s_axis_core_out       (co_if),
      .m_axis_se             (se_if)
   );

   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc = 0;
   bit    throttle = 0;
   data_t core_inc = '0;
   data_t fs_q[$];
   data_t core_q[$];
   data_t se_got[$];
   int    idx_got[$];
   bit    fs_hs, ci_hs, co_hs, se_hs, idx_hs;
   data_t ci_data;
   int    done_seen, done_cyc, last_se_cyc, first_idx_cyc;
   bit    master_valid_seen;

   task automatic check(input string tag, input data_t got, input data_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit go();
      return !throttle || bit'($urandom & 1);
   endfunction

   function automatic data_t rand_data();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: drive after the rising edge, observe handshakes at the falling edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (areset) begin
         fs_q.delete();
         core_q.delete();
         fs_if.tvalid  = 1'b0;
         co_if.tvalid  = 1'b0;
         ci_if.tready  = 1'b0;
         se_if.tready  = 1'b0;
         idx_if.tready = 1'b0;
      end else begin
         if (fs_hs) begin
            void'(fs_q.pop_front());
            fs_if.tvalid = 1'b0;
         end
         if (co_hs) begin
            void'(core_q.pop_front());
            co_if.tvalid = 1'b0;
         end
         if (ci_hs) core_q.push_back(ci_data + core_inc);
         if (!fs_if.tvalid && fs_q.size() > 0 && go()) begin
            fs_if.tdata  = fs_q[0];
            fs_if.tvalid = 1'b1;
         end
         if (!co_if.tvalid && core_q.size() > 0 && go()) begin
            co_if.tdata  = core_q[0];
            co_if.tvalid = 1'b1;
         end
         ci_if.tready  = go();
         se_if.tready  = go();
         idx_if.tready = go();
      end
      @(negedge clk);
      fs_hs   = fs_if.tvalid && fs_if.tready;
      ci_hs   = ci_if.tvalid && ci_if.tready;
      co_hs   = co_if.tvalid && co_if.tready;
      se_hs   = se_if.tvalid && se_if.tready;
      idx_hs  = idx_if.tvalid && idx_if.tready;
      ci_data = ci_if.tdata;
      if (se_hs) begin
         se_got.push_back(se_if.tdata);
         last_se_cyc = cyc;
      end
      if (idx_hs) idx_got.push_back(int'(idx_if.tdata));
      if (idx_if.tvalid && first_idx_cyc < 0) first_idx_cyc = cyc;
      if (done) begin
         done_seen++;
         done_cyc = cyc;
      end
      if (ci_if.tvalid || idx_if.tvalid || se_if.tvalid) master_valid_seen = 1'b1;
   endtask

   task automatic clear_obs();
      se_got.delete();
      idx_got.delete();
      done_seen         = 0;
      done_cyc          = -1;
      last_se_cyc       = -1;
      first_idx_cyc     = -1;
      master_valid_seen = 1'b0;
   endtask

   task automatic run_frame(input string name, input int nl, input int fb, input data_t inc,
                            input bit thr, input bit randdata, input bit glitch);
      data_t src[$];
      bit    bad;
      bit    glitched;
      int    start_cyc;
      int    guard;
      bad      = (nl == 0) || (nl > N_MAX) || (fb == 0) || ((nl > 1) && (fb > DEPTH));
      throttle = thr;
      core_inc = inc;
      glitched = 1'b0;
      if (!bad) begin
         for (int i = 0; i < fb; i++) begin
            src.push_back(randdata ? rand_data() : data_t'(i));
            fs_q.push_back(src[i]);
         end
      end
      clear_obs();
      n_layers    = CNT_BITS'(nl);
      frame_beats = CNT_BITS'(fb);
      start       = 1'b1;
      start_cyc   = cyc;
      cycle();
      start = 1'b0;
      guard = 0;
      while (done_seen == 0 && guard < GUARD) begin
         if (glitch && !glitched && idx_got.size() >= 2) begin
            glitched    = 1'b1;
            start       = 1'b1;
            n_layers    = CNT_BITS'(5);
            frame_beats = CNT_BITS'(3);
            cycle();
            start = 1'b0;
         end else begin
            cycle();
         end
         guard++;
      end
      check({name, " done_timeout"}, data_t'(done_seen > 0), data_t'(1));
      repeat (3) cycle();
      check({name, " done_count"}, data_t'(done_seen), data_t'(1));
      check({name, " done_latency"}, data_t'(done_cyc - (bad ? start_cyc : last_se_cyc)), data_t'(2));
      check({name, " busy_after"}, data_t'(busy), data_t'(0));
      check({name, " err"}, data_t'(err), data_t'(bad));
      if (bad) begin
         check({name, " no_master_valid"}, data_t'(master_valid_seen), data_t'(0));
      end else begin
         check({name, " idx_latency"}, data_t'(first_idx_cyc - start_cyc), data_t'(2));
         check({name, " idx_count"}, data_t'(idx_got.size()), data_t'(nl));
         for (int i = 0; i < idx_got.size() && i < nl; i++)
            check({name, " idx_token"}, data_t'(idx_got[i]), data_t'(i));
         check({name, " se_count"}, data_t'(se_got.size()), data_t'(fb));
         for (int i = 0; i < se_got.size() && i < fb; i++)
            check({name, " se_data"}, se_got[i], src[i] + data_t'(nl) * inc);
      end
      $display("frame %s n_layers=%0d frame_beats=%0d throttle=%0b tokens=%0d se_beats=%0d err=%0b",
               name, nl, fb, thr, idx_got.size(), se_got.size(), err);
   endtask

   initial begin
      int guard;
      fs_if.tdata   = '0;
      fs_if.tvalid  = 1'b0;
      co_if.tdata   = '0;
      co_if.tvalid  = 1'b0;
      ci_if.tready  = 1'b0;
      se_if.tready  = 1'b0;
      idx_if.tready = 1'b0;
      fs_hs = 0; ci_hs = 0; co_hs = 0; se_hs = 0; idx_hs = 0;
      ci_data = '0;
      clear_obs();

      repeat (3) cycle();
      check("rst busy", data_t'(busy), data_t'(0));
      check("rst done", data_t'(done), data_t'(0));
      check("rst err", data_t'(err), data_t'(0));
      check("rst tvalids", data_t'({ci_if.tvalid, idx_if.tvalid, se_if.tvalid}), data_t'(0));
      check("rst treadys", data_t'({fs_if.tready, co_if.tready}), data_t'(0));
      areset = 1'b0;
      cycle();

      run_frame("single_identity", 1, 4, data_t'(0), 1'b0, 1'b0, 1'b0);
      run_frame("three_layer", 3, 8, data_t'(1), 1'b0, 1'b0, 1'b0);
      run_frame("three_layer_thr", 3, 8, data_t'(1), 1'b1, 1'b0, 1'b0);
      run_frame("err_zero_layers", 0, 4, data_t'(1), 1'b0, 1'b0, 1'b0);
      check("err_sticky", data_t'(err), data_t'(1));
      run_frame("err_17_layers", 17, 4, data_t'(1), 1'b0, 1'b0, 1'b0);
      run_frame("err_fb33", 2, 33, data_t'(1), 1'b0, 1'b0, 1'b0);
      run_frame("err_fb0", 1, 0, data_t'(1), 1'b0, 1'b0, 1'b0);
      run_frame("single_long", 1, 40, data_t'(7), 1'b1, 1'b1, 1'b0);
      run_frame("max_layers_full", 16, 32, data_t'(3), 1'b1, 1'b1, 1'b0);

      // Abort a run in layer 1 of 3 with reset, then relaunch.
      throttle = 1'b0;
      core_inc = data_t'(1);
      for (int i = 0; i < 8; i++) fs_q.push_back(data_t'(i));
      clear_obs();
      n_layers    = CNT_BITS'(3);
      frame_beats = CNT_BITS'(8);
      start       = 1'b1;
      cycle();
      start = 1'b0;
      guard = 0;
      while (idx_got.size() < 2 && guard < GUARD) begin
         cycle();
         guard++;
      end
      check("midrst reached_layer1", data_t'(idx_got.size() >= 2), data_t'(1));
      repeat (2) cycle();
      areset = 1'b1;
      done_seen = 0;
      cycle();
      check("midrst busy", data_t'(busy), data_t'(0));
      check("midrst done", data_t'(done), data_t'(0));
      check("midrst tvalids", data_t'({ci_if.tvalid, idx_if.tvalid, se_if.tvalid}), data_t'(0));
      areset = 1'b0;
      repeat (4) cycle();
      check("midrst no_done", data_t'(done_seen), data_t'(0));
      $display("frame midrun_reset n_layers=3 frame_beats=8 aborted_in_layer=1");
      run_frame("after_reset", 3, 8, data_t'(1), 1'b0, 1'b0, 1'b0);

      run_frame("start_glitch", 3, 8, data_t'(1), 1'b0, 1'b0, 1'b1);

      for (int t = 0; t < 6; t++) begin
         int nl;
         int fb;
         nl = int'($urandom_range(4, 1));
         fb = (nl > 1) ? int'($urandom_range(DEPTH, 1)) : int'($urandom_range(48, 1));
         run_frame($sformatf("rand%0d", t), nl, fb, data_t'($urandom), 1'b1, 1'b1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
